// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event queue.
//   - Event word bit positions and the packed 24-bit stored event.
//   - PS/2 set-2 scan codes that drive modifier state.
//   - Default FIFO depth.
package kbd_pkg;

   localparam int KBD_EVT_DEPTH = 16;

   // Modifier scan codes
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // Event word bit positions
   localparam int EVT_CODE_LSB  = 0;
   localparam int EVT_MAKE_BIT  = 8;
   localparam int EVT_SHIFT_BIT = 9;
   localparam int EVT_CTRL_BIT  = 10;
   localparam int EVT_CAPS_BIT  = 11;
   localparam int EVT_ASCII_LSB = 16;
   localparam int EVT_W         = 24;

   // Stored event; the 32-bit bus view zero-fills bits [31:24].
   typedef struct packed {
      logic [7:0] ascii;   // [23:16]
      logic [3:0] rsvd;    // [15:12]
      logic       caps;    // [11]
      logic       ctrl;    // [10]
      logic       shift;   // [9]
      logic       make;    // [8]
      logic [7:0] code;    // [7:0]
   } kbd_event_t;

   function automatic kbd_event_t pack_event(
      input logic [7:0] code,
      input logic       make,
      input logic       shift,
      input logic       ctrl,
      input logic       caps,
      input logic [7:0] ascii
   );
      logic [EVT_W-1:0] w;
      w = '0;
      w[EVT_CODE_LSB +: 8]  = code;
      w[EVT_MAKE_BIT]       = make;
      w[EVT_SHIFT_BIT]      = shift;
      w[EVT_CTRL_BIT]       = ctrl;
      w[EVT_CAPS_BIT]       = caps;
      w[EVT_ASCII_LSB +: 8] = ascii;
      return kbd_event_t'(w);
   endfunction

endpackage

// File: rtl/kbd_event_queue_ascii_rom.sv
// kbd_ascii_rom: combinational PS/2 set-2 scan code to ASCII translation.
// Ports:
//   code  in  8 : scan code
//   shift in  1 : shift held (selects upper symbol on digits/punctuation)
//   caps  in  1 : caps-lock active (letters only, XORed with shift)
//   ascii out 8 : translated character, 0 when unmapped
module kbd_ascii_rom (
   input  logic [7:0] code,
   input  logic       shift,
   input  logic       caps,
   output logic [7:0] ascii
);

   logic       is_letter;
   logic [7:0] lower;
   logic [7:0] plain;
   logic [7:0] shifted;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      is_letter = 1'b1;
      lower     = 8'h00;
      unique case (code)
         8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
         8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
         8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
         8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
         8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
         8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
         8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
         8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
         8'h35: lower = "y";  8'h1A: lower = "z";
         default: is_letter = 1'b0;
      endcase
   end

   always_comb begin
      plain   = 8'h00;
      shifted = 8'h00;
      unique case (code)
         8'h16: begin plain = "1";  shifted = "!";  end
         8'h1E: begin plain = "2";  shifted = "@";  end
         8'h26: begin plain = "3";  shifted = "#";  end
         8'h25: begin plain = "4";  shifted = "$";  end
         8'h2E: begin plain = "5";  shifted = "%";  end
         8'h36: begin plain = "6";  shifted = "^";  end
         8'h3D: begin plain = "7";  shifted = "&";  end
         8'h3E: begin plain = "8";  shifted = "*";  end
         8'h46: begin plain = "9";  shifted = "(";  end
         8'h45: begin plain = "0";  shifted = ")";  end
         8'h0E: begin plain = 8'h60; shifted = "~";  end
         8'h4E: begin plain = "-";  shifted = "_";  end
         8'h55: begin plain = "=";  shifted = "+";  end
         8'h54: begin plain = "[";  shifted = "{";  end
         8'h5B: begin plain = "]";  shifted = "}";  end
         8'h5D: begin plain = "\\"; shifted = "|";  end
         8'h4C: begin plain = ";";  shifted = ":";  end
         8'h52: begin plain = "'";  shifted = "\""; end
         8'h41: begin plain = ",";  shifted = "<";  end
         8'h49: begin plain = ".";  shifted = ">";  end
         8'h4A: begin plain = "/";  shifted = "?";  end
         8'h29: begin plain = 8'h20; shifted = 8'h20; end  // space
         8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end  // enter
         8'h66: begin plain = 8'h08; shifted = 8'h08; end  // backspace
         default: ;
      endcase
   end

   always_comb begin
      if (is_letter)
         ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
      else
         ascii = shift ? shifted : plain;
   end

endmodule

// File: rtl/kbd_event_queue.sv
// kbd_event_queue: turns level-style key state from the keyboard decoder into
// make/break events, tracks shift/ctrl/caps-lock, attaches ASCII and queues
// the events in a show-ahead FIFO drained by CPU loads.
// Ports:
//   clk       in   1 : system clock
//   rst_n     in   1 : asynchronous active-low reset
//   key_code  in   8 : current scan code
//   key_down  in   1 : high while a key is held
//   rd_en     in   1 : pop strobe
//   clr_ovf   in   1 : clear sticky overflow
//   evt_data  out 32 : head event, 0 when empty
//   evt_valid out  1 : FIFO non-empty
//   count     out  log2(DEPTH)+1 : entries held
//   overflow  out  1 : sticky, an event was dropped
module kbd_event_queue
   import kbd_pkg::*;
#(
   parameter int DEPTH = KBD_EVT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             key_code,
   input  logic                   key_down,
   input  logic                   rd_en,
   input  logic                   clr_ovf,
   output logic [31:0]            evt_data,
   output logic                   evt_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic          prev_down;
   logic [7:0]    prev_code;
   logic          shift_q, ctrl_q, caps_q;
   logic          shift_nxt, ctrl_nxt, caps_nxt;
   logic          make_evt, break_evt, any_evt;
   logic [7:0]    evt_code;
   logic [7:0]    ascii;
   kbd_event_t    new_evt;
   logic          full, empty, push, pop, drop;
   logic [PW-1:0] wr_ptr, rd_ptr;
   kbd_event_t    mem [DEPTH];

   // A held key whose code changes counts as a new make; a break always
   // reports the code that was held, not whatever key_code shows now.
   assign make_evt  = key_down & (~prev_down | (key_code != prev_code));
   assign break_evt = ~key_down & prev_down;
   assign any_evt   = make_evt | break_evt;
   assign evt_code  = break_evt ? prev_code : key_code;

   // Modifier state after applying this cycle's event; it is what the event
   // word carries and updates even when the event itself is dropped.
   always_comb begin
      shift_nxt = shift_q;
      ctrl_nxt  = ctrl_q;
      caps_nxt  = caps_q;
      if (make_evt) begin
         if (evt_code == SC_LSHIFT || evt_code == SC_RSHIFT) shift_nxt = 1'b1;
         if (evt_code == SC_CTRL)                            ctrl_nxt  = 1'b1;
         if (evt_code == SC_CAPS)                            caps_nxt  = ~caps_q;
      end else if (break_evt) begin
         if (evt_code == SC_LSHIFT || evt_code == SC_RSHIFT) shift_nxt = 1'b0;
         if (evt_code == SC_CTRL)                            ctrl_nxt  = 1'b0;
      end
   end

   kbd_ascii_rom u_ascii_rom (
      .code  (evt_code),
      .shift (shift_nxt),
      .caps  (caps_nxt),
      .ascii (ascii)
   );

   assign new_evt = pack_event(evt_code, make_evt, shift_nxt, ctrl_nxt, caps_nxt, ascii);

   // Occupancy decides full/empty; pointers alone are ambiguous when equal.
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign pop   = rd_en & ~empty;
   assign push  = any_evt & (~full | pop);
   assign drop  = any_evt & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         prev_down <= 1'b0;
         prev_code <= 8'h00;
         shift_q   <= 1'b0;
         ctrl_q    <= 1'b0;
         caps_q    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         prev_down <= key_down;
         prev_code <= key_code;
         shift_q   <= shift_nxt;
         ctrl_q    <= ctrl_nxt;
         caps_q    <= caps_nxt;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
         // A new drop outranks a clear in the same cycle.
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_evt;
   end

   assign evt_valid = ~empty;
   assign evt_data  = empty ? 32'h0 : {8'h00, mem[rd_ptr]};

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed self-checking bench for kbd_event_queue (DEPTH = 16).
module tb_kbd_event_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  key_code = 8'h00;
   logic        key_down = 1'b0;
   logic        rd_en = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [31:0] evt_data;
   logic        evt_valid;
   logic [4:0]  count;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   kbd_event_queue #(.DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_code  (key_code),
      .key_down  (key_down),
      .rd_en     (rd_en),
      .clr_ovf   (clr_ovf),
      .evt_data  (evt_data),
      .evt_valid (evt_valid),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", evt_data, 32'h0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      step();

      // Pop on empty is ignored
      pop_one();
      check("pop_empty_count", 32'(count), 32'd0);

      // Letter make with simultaneous pop on empty: push accepted
      key_code = 8'h1C; key_down = 1'b1; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("a_make", evt_data, 32'h0061_011C);
      check("a_make_count", 32'(count), 32'd1);
      for (int i = 0; i < 4; i++) step();
      check("typematic_count", 32'(count), 32'd1);
      pop_one();
      check("a_pop_valid", 32'(evt_valid), 32'd0);
      check("a_pop_data", evt_data, 32'h0);
      key_down = 1'b0;
      step();
      check("a_break", evt_data, 32'h0061_001C);
      pop_one();
      check("a_break_pop", 32'(count), 32'd0);

      // Shifted letter, then release both
      key_code = 8'h12; key_down = 1'b1;
      step();
      check("shift_make", evt_data, 32'h0000_0312);
      pop_one();
      key_code = 8'h1C;
      step();
      check("A_make", evt_data, 32'h0041_031C);
      pop_one();
      key_down = 1'b0;
      step();
      check("A_break", evt_data, 32'h0041_021C);
      pop_one();
      key_code = 8'h12; key_down = 1'b1;
      step();
      key_down = 1'b0;
      step();
      check("shift_pair_count", 32'(count), 32'd2);
      check("shift_make2", evt_data, 32'h0000_0312);
      pop_one();
      check("shift_break", evt_data, 32'h0000_0012);
      pop_one();

      // Caps-lock toggle
      key_code = 8'h58; key_down = 1'b1;
      step();
      check("caps_make", evt_data, 32'h0000_0958);
      pop_one();
      key_down = 1'b0;
      step();
      check("caps_break", evt_data, 32'h0000_0858);
      pop_one();
      key_code = 8'h1C; key_down = 1'b1;
      step();
      check("caps_A", evt_data, 32'h0041_091C);
      pop_one();
      key_down = 1'b0;
      step();
      check("caps_A_break", evt_data, 32'h0041_081C);
      pop_one();
      key_code = 8'h58; key_down = 1'b1;
      step();
      check("caps_off", evt_data, 32'h0000_0158);
      pop_one();
      key_down = 1'b0;
      step();
      check("caps_off_break", evt_data, 32'h0000_0058);
      pop_one();
      check("caps_done_count", 32'(count), 32'd0);

      // Fill: 16 makes via code changes while held
      key_down = 1'b1;
      for (int i = 0; i < 16; i++) begin
         key_code = 8'h1C + 8'(i);
         step();
      end
      check("full_count", 32'(count), 32'd16);
      check("full_ovf0", 32'(overflow), 32'd0);
      key_code = 8'h2C;
      step();
      check("ovf_count", 32'(count), 32'd16);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_head", evt_data, 32'h0061_011C);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
      // Clear and new drop in the same cycle: set wins
      key_code = 8'h2D; clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_clr2", 32'(overflow), 32'd0);

      // Full with simultaneous push and pop
      key_code = 8'h2E; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("pp_count", 32'(count), 32'd16);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_head", evt_data, 32'h0077_011D);
      for (int i = 0; i < 15; i++) pop_one();
      check("pp_tail_count", 32'(count), 32'd1);
      check("pp_tail", evt_data, 32'h0035_012E);
      pop_one();

      // Ctrl does not change ASCII
      key_code = 8'h14;
      step();
      key_code = 8'h1C;
      step();
      check("ctrl_count", 32'(count), 32'd2);
      check("ctrl_make", evt_data, 32'h0000_0514);
      pop_one();
      check("ctrl_a", evt_data, 32'h0061_051C);
      key_code = 8'h1B;
      step();
      key_down = 1'b0;
      step();
      check("pre_rst_count", 32'(count), 32'd3);

      // Asynchronous reset mid-stream
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_valid", 32'(evt_valid), 32'd0);
      check("arst_data", evt_data, 32'h0);
      #1 rst_n = 1'b1;
      key_code = 8'h1C; key_down = 1'b1;
      step();
      check("post_rst_make", evt_data, 32'h0061_011C);
      check("post_rst_count", 32'(count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/kbd_event_queue.md
# kbd_event_queue

Buffers PS/2 keyboard activity for the CPU. Sits directly downstream of the `keyboard` decoder (its `key_code`/`key_down` outputs) and upstream of the memory-mapped read mux. It converts level-style key state into discrete make/break events, tracks modifier state, attaches an ASCII translation, and queues the events in a FIFO. The CPU drains the FIFO one word per load.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, ≥2.
- `clk`  in  1: system clock (CLK50MHZ domain, same as `keyboard`).
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_code`  in  8: current scan code from `keyboard`.
- `key_down`  in  1: high while a key is held.
- `rd_en`  in  1: pop strobe, one cycle per CPU load of the event register.
- `clr_ovf`  in  1: clears the sticky overflow flag.
- `evt_data`  out  32: head event (show-ahead); 0 when empty.
- `evt_valid`  out  1: FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1: entries held.
- `overflow`  out  1: sticky; an event was dropped.

## Operation
- Event word layout:
  - [7:0] scan code.
  - [8] make=1 / break=0.
  - [9] shift.
  - [10] ctrl.
  - [11] caps-lock.
  - [23:16] ASCII, 0 if unmapped.
  - all other bits 0.
- Detection compares the inputs against registered `prev_down`/`prev_code`:
  - make: `key_down` rises, OR `key_down` stays high and `key_code` changes. Code field = new `key_code`.
  - break: `key_down` falls. Code field = `prev_code`, even if `key_code` also changed that cycle.
  - `key_down` high with `key_code` unchanged (typematic hold): no event.
- Modifier codes:
  - shift: 0x12, 0x59. Set on make, clear on break.
  - ctrl: 0x14. Set on make, clear on break.
  - caps-lock: 0x58. Toggles on make only.
  - Bits [11:9] of an event reflect modifier state *after* applying that event.
- ASCII is computed from the code, shift XOR caps (letters only), and shift (digits/symbols). Ctrl does not alter ASCII.
- FIFO push/pop rules:
  - Push on any detected event when not full.
  - When full: the event is dropped and `overflow`←1. Modifier state still updates.
  - Pop on `rd_en` when non-empty. `rd_en` when empty is ignored.
  - Simultaneous push and pop when full: both occur, `count` unchanged, `overflow` not set.
  - Simultaneous push and pop when empty: the push is accepted, the pop is ignored.
- Overflow: if `clr_ovf` and a new overflow occur in the same cycle, set wins.

## Timing
- Reset values: pointers 0; `count` 0; `evt_valid` 0; `evt_data` 0; `overflow` 0; modifiers 0; `prev_down` 0; `prev_code` 0.
- Reset is asynchronous and can land mid-operation. All queued events are discarded, and the next event is judged against `prev_*`=0.
- Latency: an input change sampled at edge k is pushed at edge k. `evt_valid`/`evt_data` are valid after edge k (1 cycle).
- Pop at edge k: the new head appears on `evt_data` after edge k.
- `count` and `evt_valid` are registered-consistent: both are updated at the same edge as the pointers.
- The pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by `count`, not by pointer equality.

## Structure
- Package `kbd_pkg`:
  - Event bit positions and a `kbd_event_t` packed struct.
  - Modifier scan-code constants (`SC_LSHIFT`, `SC_RSHIFT`, `SC_CTRL`, `SC_CAPS`).
  - `KBD_EVT_DEPTH` default.
- Sub-module `kbd_ascii_rom`: combinational; inputs code, shift, caps; output 8-bit ASCII. Covers letters, digits, space, enter, backspace and the common punctuation set.
- Storage: FIFO array of 24-bit entries. The upper 8 bits of `evt_data` are zero-filled.

## Test plan
- Letter make/break: `key_code`=0x1C, `key_down` 0→1, then after 5 cycles 1→0. Required: `evt_data`=0x0061_011C after the first edge; pop; then 0x0061_001C; `count` returns to 0.
- Shifted letter: press 0x12, then 0x1C (0x12 still held in modifier state). Required events: 0x0000_0312, then 0x0041_031C.
- Caps toggle: make 0x58 → 0x0000_0958; make 0x1C → 0x0041_091C; make 0x58 again → caps bit 0.
- Overflow with DEPTH=16: 17 make events, no pops. Required: `count`=16, `overflow`=1, head = first event; `clr_ovf` → `overflow`=0.
- Full with simultaneous push+pop: `count` stays 16, the old head is removed, the new event is at the tail, and `overflow` stays 0.
- Reset mid-stream: 3 events queued, then assert `rst_n`=0 asynchronously. Required: `evt_valid`=0 and `count`=0 immediately; the next `key_down` rise yields a make event.
